// File: rtl/sd_cmd_pkg.sv
// Shared encodings for the SD host command path: FSM states, frame/response field layout.
// Consumed by sd_cmd_controller (optional index check: CMD_RESP_INDEX_CHECK_EN).
package sd_cmd_pkg;

  localparam int CMD_W        = 40;
  localparam int RESP_W       = 136;
  localparam int ARG_W        = 32;
  localparam int IDX_W        = 6;
  localparam int ARG_LSB      = 0;
  localparam int IDX_LSB      = ARG_LSB + ARG_W;
  localparam int DIR_POS      = IDX_LSB + IDX_W;
  localparam int START_POS    = DIR_POS + 1;
  localparam int RESP_DATA_W  = 128;
  localparam int RESP_IDX_LSB = RESP_DATA_W;

  localparam logic START_BIT = 1'b0;
  localparam logic DIR_HOST  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_ACK
  } cmd_state_e;

  // PHY appends CRC7 and the end bit; the host only supplies the leading 40 bits.
  function automatic logic [CMD_W-1:0] build_frame(input logic [IDX_W-1:0] idx,
                                                   input logic [ARG_W-1:0] arg);
    return {START_BIT, DIR_HOST, idx, arg};
  endfunction

endpackage

// File: rtl/sd_cmd_controller.sv
// SD host command-path controller: issues a 40-bit frame to the PHY, captures the response.
// Build option: define CMD_RESP_INDEX_CHECK_EN to flag response index mismatches on index_error.
module sd_cmd_controller
  import sd_cmd_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   new_command,
  input  logic [ARG_W-1:0]       cmd_argument,
  input  logic [IDX_W-1:0]       cmd_index,
  input  logic                   TIMEOUT_ENABLE,
  input  logic                   TIMEOUT,
  input  logic                   ack_in,
  input  logic                   strobe_in,
  input  logic [RESP_W-1:0]      cmd_in,
  output logic                   strobe_out,
  output logic                   ack_out,
  output logic [CMD_W-1:0]       cmd_out,
  output logic [RESP_DATA_W-1:0] response,
  output logic                   command_complete,
  output logic                   command_timeout,
  output logic                   index_error
);

  cmd_state_e             state_q, state_d;
  logic [CMD_W-1:0]       cmd_out_q, cmd_out_d;
  logic [RESP_DATA_W-1:0] response_q, response_d;
  logic                   strobe_out_q, strobe_out_d;
  logic                   ack_out_q, ack_out_d;
  logic                   complete_q, complete_d;
  logic                   timeout_q, timeout_d;
  logic                   index_error_q, index_error_d;
  logic                   capture;
  logic                   timeout_hit;

  assign timeout_hit = TIMEOUT_ENABLE & TIMEOUT;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cmd_out_d    = cmd_out_q;
    response_d   = response_q;
    strobe_out_d = strobe_out_q;
    ack_out_d    = ack_out_q;
    complete_d   = 1'b0;
    timeout_d    = 1'b0;
    capture      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (new_command) begin
          cmd_out_d    = build_frame(cmd_index, cmd_argument);
          strobe_out_d = 1'b1;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        // Timeout outranks a same-cycle PHY accept.
        if (timeout_hit) begin
          strobe_out_d = 1'b0;
          timeout_d    = 1'b1;
          state_d      = ST_IDLE;
        end else if (ack_in) begin
          strobe_out_d = 1'b0;
          state_d      = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (strobe_in) begin
          response_d = cmd_in[RESP_DATA_W-1:0];
          capture    = 1'b1;
          ack_out_d  = 1'b1;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        // Once the response is captured the transfer always finishes; TIMEOUT is ignored.
        if (!strobe_in) begin
          ack_out_d  = 1'b0;
          complete_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        strobe_out_d = 1'b0;
        ack_out_d    = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

`ifdef CMD_RESP_INDEX_CHECK_EN
  always_comb begin
    index_error_d = index_error_q;
    if (capture) begin
      index_error_d = (cmd_in[RESP_IDX_LSB +: IDX_W] != cmd_out_q[IDX_LSB +: IDX_W]);
    end
  end

  logic unused_cmd_in;
  assign unused_cmd_in = ^cmd_in[RESP_W-1:RESP_IDX_LSB+IDX_W];
`else
  assign index_error_d = 1'b0;

  logic unused_cmd_in;
  assign unused_cmd_in = ^{cmd_in[RESP_W-1:RESP_DATA_W], capture};
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_out_q     <= '0;
      response_q    <= '0;
      strobe_out_q  <= 1'b0;
      ack_out_q     <= 1'b0;
      complete_q    <= 1'b0;
      timeout_q     <= 1'b0;
      index_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_out_q     <= cmd_out_d;
      response_q    <= response_d;
      strobe_out_q  <= strobe_out_d;
      ack_out_q     <= ack_out_d;
      complete_q    <= complete_d;
      timeout_q     <= timeout_d;
      index_error_q <= index_error_d;
    end
  end

  assign strobe_out       = strobe_out_q;
  assign ack_out          = ack_out_q;
  assign cmd_out          = cmd_out_q;
  assign response         = response_q;
  assign command_complete = complete_q;
  assign command_timeout  = timeout_q;
  assign index_error      = index_error_q;

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Scoreboard bench for sd_cmd_controller: a driver plays host and PHY with randomized timing,
// a negedge monitor pops expected frames/outcomes and compares them against the DUT.
module tb_sd_cmd_controller;

  logic          clock = 1'b0;
  logic          reset;
  logic          new_command;
  logic [31:0]   cmd_argument;
  logic [5:0]    cmd_index;
  logic          TIMEOUT_ENABLE;
  logic          TIMEOUT;
  logic          ack_in;
  logic          strobe_in;
  logic [135:0]  cmd_in;
  logic          strobe_out;
  logic          ack_out;
  logic [39:0]   cmd_out;
  logic [127:0]  response;
  logic          command_complete;
  logic          command_timeout;
  logic          index_error;

  sd_cmd_controller dut (
    .clock            (clock),
    .reset            (reset),
    .new_command      (new_command),
    .cmd_argument     (cmd_argument),
    .cmd_index        (cmd_index),
    .TIMEOUT_ENABLE   (TIMEOUT_ENABLE),
    .TIMEOUT          (TIMEOUT),
    .ack_in           (ack_in),
    .strobe_in        (strobe_in),
    .cmd_in           (cmd_in),
    .strobe_out       (strobe_out),
    .ack_out          (ack_out),
    .cmd_out          (cmd_out),
    .response         (response),
    .command_complete (command_complete),
    .command_timeout  (command_timeout),
    .index_error      (index_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit           is_timeout;
    logic [127:0] resp;
    logic         ierr;
  } outcome_t;

  outcome_t     exp_q[$];
  logic [39:0]  frame_q[$];
  int           total = 0;
  int           bad   = 0;

  // Reference state: what the host should observe as the last captured response.
  logic [127:0] model_resp = '0;
  logic         model_ierr = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Monitor: a new frame appears when strobe_out rises; a transaction ends on a done pulse.
  logic prev_strobe = 1'b0;
  always @(negedge clock) begin : monitor
    outcome_t e;
    if (strobe_out && !prev_strobe) begin
      if (frame_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_frame: got cmd_out %0h with no command issued", cmd_out);
      end else begin
        check("cmd_out", cmd_out, frame_q.pop_front());
      end
    end
    if (command_complete || command_timeout) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: complete=%0b timeout=%0b with nothing pending",
                 command_complete, command_timeout);
      end else begin
        e = exp_q.pop_front();
        check("done_kind_timeout", command_timeout, e.is_timeout);
        check("done_exclusive", command_complete & command_timeout, 0);
        check("response", response, e.resp);
        check("index_error", index_error, e.ierr);
      end
    end
    prev_strobe = strobe_out;
  end

  task automatic idle_inputs();
    new_command    = 1'b0;
    TIMEOUT        = 1'b0;
    TIMEOUT_ENABLE = 1'($urandom % 2);
    ack_in         = 1'b0;
    strobe_in      = 1'b0;
  endtask

  // Busy-phase disturbance that must have no effect: stray new_command, TIMEOUT while disabled.
  task automatic noise();
    new_command    = ($urandom % 3) == 0;
    cmd_index      = 6'($urandom);
    cmd_argument   = $urandom;
    TIMEOUT_ENABLE = 1'b0;
    TIMEOUT        = 1'($urandom % 2);
  endtask

  task automatic clear_noise();
    new_command = 1'b0;
    TIMEOUT     = 1'b0;
  endtask

  // kind: 0 = normal completion, 1 = timeout in SEND, 2 = timeout in WAIT_RESP.
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input int kind,
                         input logic [127:0] data, input logic [5:0] ridx);
    outcome_t     e;
    logic [135:0] rsp;
    logic [39:0]  frame;
    rsp   = {2'($urandom), ridx, data};
    frame = {1'b0, 1'b1, idx, arg};
    frame_q.push_back(frame);
    if (kind == 0) begin
      model_resp = data;
`ifdef CMD_RESP_INDEX_CHECK_EN
      model_ierr = (ridx != idx);
`else
      model_ierr = 1'b0;
`endif
    end
    e.is_timeout = (kind != 0);
    e.resp       = model_resp;
    e.ierr       = model_ierr;
    exp_q.push_back(e);

    idle_inputs();
    new_command  = 1'b1;
    cmd_index    = idx;
    cmd_argument = arg;
    cyc();
    new_command  = 1'b0;
    cmd_index    = 6'($urandom);
    cmd_argument = $urandom;
    check("strobe_after_issue", strobe_out, 1);

    repeat ($urandom_range(0, 3)) begin
      noise();
      cyc();
      check("strobe_held", strobe_out, 1);
    end
    clear_noise();

    if (kind == 1) begin
      TIMEOUT_ENABLE = 1'b1;
      TIMEOUT        = 1'b1;
      ack_in         = 1'($urandom % 2);
      cyc();
      idle_inputs();
      check("strobe_after_timeout", strobe_out, 0);
      cyc();
      return;
    end

    ack_in = 1'b1;
    cyc();
    ack_in = 1'b0;
    check("strobe_drop_on_ack", strobe_out, 0);

    repeat ($urandom_range(0, 3)) begin
      noise();
      cyc();
      check("ack_out_wait", ack_out, 0);
    end
    clear_noise();

    if (kind == 2) begin
      TIMEOUT_ENABLE = 1'b1;
      TIMEOUT        = 1'b1;
      strobe_in      = 1'($urandom % 2);
      cmd_in         = rsp;
      cyc();
      idle_inputs();
      check("ack_out_after_timeout", ack_out, 0);
      cyc();
      return;
    end

    strobe_in = 1'b1;
    cmd_in    = rsp;
    cyc();
    check("ack_out_on_capture", ack_out, 1);
    check("response_capture", response, data);

    repeat ($urandom_range(0, 2)) begin
      cmd_in         = {$urandom, $urandom, $urandom, $urandom, $urandom};
      TIMEOUT_ENABLE = 1'b1;
      TIMEOUT        = 1'($urandom % 2);
      cyc();
      check("ack_out_held", ack_out, 1);
    end
    strobe_in = 1'b0;
    cyc();
    check("ack_out_release", ack_out, 0);
    idle_inputs();
    cyc();
    check("complete_one_cycle", command_complete, 0);
    check("frame_held", cmd_out, frame);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || frame_q.size() != 0) && n < 8) begin
      cyc();
      n++;
    end
    if (exp_q.size() != 0 || frame_q.size() != 0) begin
      total++; bad++;
      $display("FAIL outcome_missing: got %0d outcomes and %0d frames unobserved, required 0",
               exp_q.size(), frame_q.size());
      exp_q.delete();
      frame_q.delete();
    end
  endtask

  task automatic reset_in_send(input logic [5:0] idx, input logic [31:0] arg);
    frame_q.push_back({1'b0, 1'b1, idx, arg});
    idle_inputs();
    new_command  = 1'b1;
    cmd_index    = idx;
    cmd_argument = arg;
    cyc();
    new_command = 1'b0;
    check("strobe_before_reset", strobe_out, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    model_resp = '0;
    model_ierr = 1'b0;
    check("rst_strobe_out", strobe_out, 0);
    check("rst_ack_out", ack_out, 0);
    check("rst_cmd_out", cmd_out, 0);
    check("rst_response", response, 0);
    check("rst_complete", command_complete, 0);
    check("rst_timeout", command_timeout, 0);
    check("rst_index_error", index_error, 0);
    cyc();
    check("idle_after_reset", strobe_out, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [5:0]   idx;
    logic [5:0]   ridx;
    logic [127:0] data;
    reset        = 1'b1;
    cmd_in       = '0;
    cmd_index    = '0;
    cmd_argument = '0;
    idle_inputs();
    repeat (2) cyc();
    check("init_strobe_out", strobe_out, 0);
    check("init_cmd_out", cmd_out, 0);
    check("init_response", response, 0);
    check("init_ack_out", ack_out, 0);
    check("init_index_error", index_error, 0);
    reset = 1'b0;
    cyc();

    run_txn(6'd7, 32'h0, 0, 128'h315, 6'd7);
    drain();
    check("first_frame_value", cmd_out, 40'h47_0000_0000);
    run_txn(6'd7, $urandom, 0, {$urandom, $urandom, $urandom, $urandom}, 6'd8);
    drain();
    run_txn(6'd7, $urandom, 0, {$urandom, $urandom, $urandom, $urandom}, 6'd7);
    drain();
    run_txn(6'd12, $urandom, 1, '0, 6'd12);
    drain();
    run_txn(6'd13, $urandom, 2, {$urandom, $urandom, $urandom, $urandom}, 6'd1);
    drain();

    reset_in_send(6'd17, 32'hdead_beef);
    drain();
    run_txn(6'd18, 32'h1234_5678, 0, 128'hcafe, 6'd18);
    drain();

    repeat (40) begin
      idx  = 6'($urandom);
      ridx = ($urandom % 2) ? idx : 6'($urandom);
      data = {$urandom, $urandom, $urandom, $urandom};
      run_txn(idx, $urandom, int'($urandom_range(0, 5) / 3 == 0 ? 0 : $urandom_range(1, 2)),
              data, ridx);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
